// File: rtl/trit_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trit_pack_pkg
// Description : Shared constants and enumerations for the trit/byte
//               stream converter (NTRU-HRSS polynomial (de)serialisation).
// Revision    : 1.0 - initial release
// ============================================================================
package trit_pack_pkg;

  localparam int TRIT_W      = 2;
  localparam int GROUP_TRITS = 5;
  localparam int LANE_W      = 10;
  localparam int BYTE_MAX    = 242;
  localparam int DIV3_MUL    = 171;
  localparam int DIV3_SHIFT  = 9;
  // Step counter width: holds 0..GROUP_TRITS-1
  localparam int CNT_W       = 3;

  typedef enum logic {
    MODE_PACK   = 1'b0,
    MODE_UNPACK = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/trit5_lane.sv
`default_nettype none
// ============================================================================
// Module      : trit5_lane
// Description : One iterative 5-trit <-> byte converter. Pack runs Horner
//               from the top trit down; unpack peels one base-3 digit per
//               step using a multiply-shift divide-by-3. The result/err
//               outputs show the value after the current step completes,
//               so the final step's result can be captured on that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module trit5_lane
  import trit_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  mode_e             mode,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [LANE_W-1:0] din,
  output logic [LANE_W-1:0] result,
  output logic              err
);

  mode_e             mode_q, mode_d;
  logic [LANE_W-1:0] src_q, src_d;
  logic [LANE_W-1:0] acc_q, acc_d;
  logic [LANE_W-1:0] dig_q, dig_d;
  logic              err_q, err_d;
  logic [TRIT_W-1:0] trit;
  logic [7:0]        quo;
  logic [1:0]        rem;

  // Next-state datapath: latch on start, one pack or unpack step per step
  always_comb begin
    mode_d = mode_q;
    src_d  = src_q;
    acc_d  = acc_q;
    dig_d  = dig_q;
    err_d  = err_q;

    // Horner consumes trit 4 first, trit 0 last
    case (cnt)
      3'd0:    trit = src_q[9:8];
      3'd1:    trit = src_q[7:6];
      3'd2:    trit = src_q[5:4];
      3'd3:    trit = src_q[3:2];
      default: trit = src_q[1:0];
    endcase

    // Exact floor(v/3) for v <= 255
    quo = 8'((17'(acc_q[7:0]) * 17'(DIV3_MUL)) >> DIV3_SHIFT);
    rem = 2'(acc_q[7:0] - quo * 8'd3);

    if (start) begin
      mode_d = mode;
      src_d  = din;
      dig_d  = '0;
      if (mode == MODE_UNPACK) begin
        acc_d = {2'b00, din[7:0]};
        err_d = (din[7:0] > 8'(BYTE_MAX));
      end else begin
        acc_d = '0;
        err_d = 1'b0;
      end
    end else if (step) begin
      if (mode_q == MODE_PACK) begin
        // Code 2'b11 is not a trit: count it as zero and flag the lane
        if (trit == 2'b11) begin
          trit  = 2'b00;
          err_d = 1'b1;
        end
        acc_d = acc_q * 10'd3 + 10'(trit);
      end else begin
        dig_d = dig_q | (10'(rem) << {cnt, 1'b0});
        acc_d = 10'(quo);
      end
    end

    result = (mode_q == MODE_UNPACK) ? dig_d : {2'b00, acc_d[7:0]};
    err    = err_d;
  end

  // Lane state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_PACK;
      src_q  <= '0;
      acc_q  <= '0;
      dig_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      src_q  <= src_d;
      acc_q  <= acc_d;
      dig_q  <= dig_d;
      err_q  <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/trit_pack_stream.sv
`default_nettype none
// ============================================================================
// Module      : trit_pack_stream
// Description : LANES parallel trit/byte converters behind one valid/ready
//               input, a shared IDLE/RUN sequencer with a 5-step counter,
//               and an output FIFO carrying data plus per-lane error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module trit_pack_stream
  import trit_pack_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic [LANES-1:0]        out_err,
  output logic                    busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;
  localparam int DATA_W = LANES * LANE_W;
  localparam int ENT_W  = DATA_W + LANES;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               rdy_en_q, rdy_en_d;

  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

  logic [DATA_W-1:0]  lane_res;
  logic [LANES-1:0]   lane_err;
  logic               fifo_full, accept, step, push, pop;

  // Handshake and FIFO control strobes; flush masks every state change
  always_comb begin
    fifo_full = (fcnt_q == FCNT_W'(FIFO_DEPTH));
    in_ready  = rdy_en_q && (state_q == ST_IDLE) && !fifo_full && !flush;
    accept    = in_valid && in_ready;
    step      = (state_q == ST_RUN) && !flush;
    push      = step && (cnt_q == CNT_W'(GROUP_TRITS - 1));
    out_valid = (fcnt_q != '0);
    pop       = out_ready && out_valid && !flush;
    {out_err, out_data} = mem_q[rd_q];
    busy      = busy_q;
  end

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      trit5_lane u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept),
        .step   (step),
        .mode   (mode_e'(mode)),
        .cnt    (cnt_q),
        .din    (in_data[k*LANE_W +: LANE_W]),
        .result (lane_res[k*LANE_W +: LANE_W]),
        .err    (lane_err[k])
      );
    end
  endgenerate

  // Sequencer next state: accept starts a group, five steps finish it
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdy_en_d = 1'b1;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          if (cnt_q == CNT_W'(GROUP_TRITS - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
    busy_d = (state_d == ST_RUN);
  end

  // Sequencer registers; rdy_en_q keeps in_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  // FIFO next state; a push into a full FIFO cannot happen since accept needs a free slot
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    fcnt_d = fcnt_q;
    if (flush) begin
      wr_d   = '0;
      rd_d   = '0;
      fcnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = {lane_err, lane_res};
        wr_d        = wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fcnt_d = fcnt_q + FCNT_W'(1);
        2'b01:   fcnt_d = fcnt_q - FCNT_W'(1);
        default: fcnt_d = fcnt_q;
      endcase
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fcnt_q <= fcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trit_pack_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_trit_pack_stream
// Description : Self-checking bench for trit_pack_stream with a base-3
//               arithmetic reference model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trit_pack_stream;

  localparam int L = 4;
  localparam int D = 4;
  localparam int W = L * 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] out_data;
  logic [L-1:0] out_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W+L-1:0] exp_q[$];

  always #5 clk = ~clk;

  trit_pack_stream #(.LANES(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .busy(busy)
  );

  // Reference: pack = sum t_i*3^i (code 3 counts as 0, flags err);
  // unpack = base-3 digits of (byte mod 243), err when byte > 242.
  function automatic logic [W+L-1:0] model(input logic m, input logic [W-1:0] d);
    logic [W-1:0] od;
    logic [L-1:0] oe;
    int val, p, t, v;
    od = '0;
    oe = '0;
    for (int k = 0; k < L; k++) begin
      if (!m) begin
        val = 0;
        p   = 1;
        for (int i = 0; i < 5; i++) begin
          t = int'(d[10*k+2*i +: 2]);
          if (t == 3) begin
            oe[k] = 1'b1;
            t = 0;
          end
          val = val + t * p;
          p   = p * 3;
        end
        od[10*k +: 10] = 10'(val);
      end else begin
        v = int'(d[10*k +: 8]);
        oe[k] = (v > 242);
        v = v % 243;
        for (int i = 0; i < 5; i++) begin
          od[10*k+2*i +: 2] = 2'(v % 3);
          v = v / 3;
        end
      end
    end
    return {oe, od};
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] r;
    for (int k = 0; k < L; k++) r[10*k +: 10] = 10'($urandom);
    return r;
  endfunction

  // Offer one group from a negedge; returns at T+0.5 after the accept edge
  task automatic do_accept(input logic m, input logic [W-1:0] d, output bit ok);
    int n;
    n = 0;
    mode = m;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (ok) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    mode = 1'($urandom);
    in_data = rand_data();
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    ok = out_valid;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h exp 0", out_data); end
    n_checks++; if (out_err !== '0) begin n_fail++; $display("FAIL rst_out_err: got %h exp 0", out_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b exp 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_pack_basic(input string tag);
    logic [W-1:0] d;
    logic [W+L-1:0] e;
    bit ok;
    d = '0;
    d[9:0] = 10'h186;
    e = model(1'b0, d);
    do_accept(1'b0, d, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL %s_accept: timeout", tag); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_run: busy %b ready %b exp 1 0", tag, busy, in_ready); end
    repeat (3) begin @(posedge clk); @(negedge clk); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid: got %b exp 0", tag, out_valid); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid_t5: got %b exp 1", tag, out_valid); end
    n_checks++; if (out_data[9:0] !== 10'h08C || out_err[0] !== 1'b0) begin n_fail++; $display("FAIL %s_byte: got %h err %b exp 08c err 0", tag, out_data[9:0], out_err[0]); end
    n_checks++; if ({out_err, out_data} !== e) begin n_fail++; $display("FAIL %s_model: got %h exp %h", tag, {out_err, out_data}, e); end
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle: ready %b busy %b exp 1 0", tag, in_ready, busy); end
    pop_one();
  endtask

  task automatic test_unpack();
    logic [7:0] bytes [2];
    logic [9:0] exp_lane [2];
    logic       exp_e [2];
    logic [W-1:0] d;
    logic [W+L-1:0] e;
    bit ok;
    bytes = '{8'hF2, 8'hFF};
    exp_lane = '{10'h2AA, 10'h014};
    exp_e = '{1'b0, 1'b1};
    for (int i = 0; i < 2; i++) begin
      d = rand_data();
      d[7:0] = bytes[i];
      e = model(1'b1, d);
      do_accept(1'b1, d, ok);
      wait_valid(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL unpack_timeout_%0d: no out_valid", i); end
      n_checks++; if (out_data[9:0] !== exp_lane[i] || out_err[0] !== exp_e[i]) begin n_fail++; $display("FAIL unpack_%0d: got %h err %b exp %h err %b", i, out_data[9:0], out_err[0], exp_lane[i], exp_e[i]); end
      n_checks++; if ({out_err, out_data} !== e) begin n_fail++; $display("FAIL unpack_model_%0d: got %h exp %h", i, {out_err, out_data}, e); end
      pop_one();
    end
  endtask

  task automatic test_illegal();
    logic [9:0] pats [2];
    logic [W-1:0] d;
    logic [W+L-1:0] e;
    bit ok;
    pats = '{10'h030, 10'h3FF};
    for (int i = 0; i < 2; i++) begin
      d = rand_data();
      d[9:0] = pats[i];
      e = model(1'b0, d);
      do_accept(1'b0, d, ok);
      wait_valid(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL illegal_timeout_%0d: no out_valid", i); end
      n_checks++; if (out_data[9:0] !== 10'h000 || out_err[0] !== 1'b1) begin n_fail++; $display("FAIL illegal_%0d: got %h err %b exp 000 err 1", i, out_data[9:0], out_err[0]); end
      n_checks++; if ({out_err, out_data} !== e) begin n_fail++; $display("FAIL illegal_model_%0d: got %h exp %h", i, {out_err, out_data}, e); end
      pop_one();
    end
  endtask

  task automatic test_multilane();
    logic [W-1:0] d;
    logic [W-1:0] want;
    bit ok;
    d    = {10'h155, 10'h186, 10'h2AA, 10'h000};
    want = {10'd121, 10'd140, 10'd242, 10'd0};
    do_accept(1'b0, d, ok);
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL multilane_timeout: no out_valid"); end
    n_checks++; if (out_data !== want || out_err !== '0) begin n_fail++; $display("FAIL multilane: got %h err %h exp %h err 0", out_data, out_err, want); end
    pop_one();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d;
    logic m;
    bit ok;
    int seen_ready, got, n;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = rand_data();
      m = 1'($urandom);
      do_accept(m, d, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_accept_%0d: timeout", i); end
      exp_q.push_back(model(m, d));
    end
    d = rand_data();
    m = 1'($urandom);
    mode = m;
    in_data = d;
    in_valid = 1'b1;
    seen_ready = 0;
    repeat (12) begin
      if (in_ready) seen_ready++;
      @(posedge clk); @(negedge clk);
    end
    n_checks++; if (seen_ready != 0) begin n_fail++; $display("FAIL bp_full_ready: got %0d ready cycles exp 0", seen_ready); end
    n_checks++; if (out_valid !== 1'b1 || {out_err, out_data} !== exp_q[0]) begin n_fail++; $display("FAIL bp_head: got %h exp %h", {out_err, out_data}, exp_q[0]); end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b exp 1", in_ready); end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    exp_q.push_back(model(m, d));
    got = 0;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      if (out_valid) begin
        n_checks++; if ({out_err, out_data} !== exp_q[0]) begin n_fail++; $display("FAIL bp_order_%0d: got %h exp %h", got, {out_err, out_data}, exp_q[0]); end
        void'(exp_q.pop_front());
        got++;
      end
      @(posedge clk); @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL bp_drain_count: got %0d exp 4", got); end
  endtask

  task automatic test_random();
    int got;
    exp_q.delete();
    got = 0;
    fork
      begin
        logic [W-1:0] d;
        logic m;
        bit ok;
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); @(negedge clk); end
          d = rand_data();
          m = 1'($urandom);
          do_accept(m, d, ok);
          if (ok) exp_q.push_back(model(m, d));
        end
      end
      begin
        int n;
        n = 0;
        while (got < 24 && n < 800) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL rand_unexpected: got %h exp none", {out_err, out_data});
            end else begin
              if ({out_err, out_data} !== exp_q[0]) begin n_fail++; $display("FAIL rand_item_%0d: got %h exp %h", got, {out_err, out_data}, exp_q[0]); end
              void'(exp_q.pop_front());
            end
            got++;
          end
          @(posedge clk); @(negedge clk);
          n++;
        end
        out_ready = 1'b0;
      end
    join
    n_checks++; if (got != 24) begin n_fail++; $display("FAIL rand_count: got %0d exp 24", got); end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    int seen;
    do_accept(1'b0, rand_data(), ok);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b exp 1", busy); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_async: valid %b busy %b ready %b exp 0 0 0", out_valid, busy, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_ghost_output: got %0d valid cycles exp 0", seen); end
  endtask

  task automatic test_flush();
    bit ok;
    int seen;
    out_ready = 1'b0;
    do_accept(1'b0, rand_data(), ok);
    do_accept(1'b1, rand_data(), ok);
    repeat (6) begin @(posedge clk); @(negedge clk); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_prefill: got %b exp 1", out_valid); end
    flush = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b exp 0", in_ready); end
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_clear: valid %b busy %b exp 0 0", out_valid, busy); end
    seen = 0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_stale: got %0d valid cycles exp 0", seen); end
    test_pack_basic("post_flush");
  endtask

  initial begin
    test_reset();
    test_pack_basic("pack");
    test_unpack();
    test_illegal();
    test_multilane();
    test_backpressure();
    test_random();
    test_reset_midrun();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/trit_pack_stream.md
Name: trit_pack_stream

Overview:
- Parametrised, bidirectional trit/byte converter for the NTRU-HRSS polynomial (de)serialisation path.
- Pack mode: each lane maps 5 trits (2-bit codes) to one byte, value = sum t_i*3^i, range 0..242.
- Unpack mode: each lane maps one byte back to 5 trits.
- LANES independent iterative cores share one valid/ready handshake and feed a shared output FIFO; the block sits between the coefficient buffer and the byte-stream interface.

Parameters:
- LANES, 1, number of 5-trit groups converted in parallel per transaction.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear: aborts the in-flight group and empties the FIFO.
- mode  in  1  0 = pack, 1 = unpack; sampled only at input accept.
- in_valid  in  1  in_data/mode valid.
- in_ready  out  1  block can accept.
- in_data  in  LANES*10  lane k occupies bits [10k+9:10k].
  - Pack: trit i at [2i+1:2i].
  - Unpack: byte in the low 8 bits; upper 2 bits ignored.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_data  out  LANES*10  same lane slots.
  - Pack: byte in the low 8 bits; upper 2 bits zero.
  - Unpack: 5 trits.
- out_err  out  LANES  per-lane error flag, travels with out_data.
- busy  out  1  core in RUN.

Behaviour:
- Reset (rst_n=0, async):
  - FSM goes to IDLE, cnt=0, FIFO empty.
  - in_ready=0 while rst_n=0; in_ready=1 from the first edge after release.
  - out_valid=0, out_data=0, out_err=0, busy=0.
  - An in-flight group is discarded.
- FSM states IDLE and RUN.
  - in_ready = IDLE && !fifo_full && !flush.
  - Accept = in_valid && in_ready at edge T: latch data and mode per lane, cnt=0, go to RUN.
  - RUN performs one step per edge, at T+1..T+5 (cnt 0..4).
  - At the T+5 edge the result is pushed to the FIFO and the FSM returns to IDLE.
  - out_valid is high from T+5 when the FIFO was empty.
  - in_ready is high again from T+5. A new accept can occur at T+6, so throughput is 1 transaction per 6 cycles.
- Pack step k (Horner): acc = acc*3 + t[4-k], with a 10-bit internal accumulator.
  - Trit code 2'b11 is illegal: it is used as 0 and sets the lane's err bit.
  - The result is always <=242.
- Unpack step k:
  - digit[k] = v mod 3, v = v/3.
  - Quotient = (v*171)>>9, exact for v<=255; remainder = v - 3*q.
  - Input >242 sets err; output is then the base-3 digits of (input mod 243), which is what the algorithm naturally yields.
- FIFO:
  - Push and pop in the same cycle when full: the pop frees the slot and the push succeeds. When full, no accept is possible, so no push can be pending.
  - Pop when empty is ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH, with a count register of width clog2(FIFO_DEPTH)+1.
  - out_data and out_err are driven from the head entry; both hold stable while out_valid && !out_ready.
- flush:
  - Takes priority over accept, push and pop.
  - Next cycle: IDLE, FIFO empty, out_valid=0.
- mode changes while in RUN have no effect on the group in flight.

Decomposition:
- Package trit_pack_pkg:
  - TRIT_W=2, GROUP_TRITS=5, LANE_W=10, BYTE_MAX=242, DIV3_MUL=171, DIV3_SHIFT=9.
  - typedef enum {MODE_PACK, MODE_UNPACK}.
  - typedef enum {ST_IDLE, ST_RUN}.
- Sub-module trit5_lane:
  - One iterative pack/unpack datapath with start and step inputs and result/err outputs.
  - Instantiated LANES times.
  - The top holds the FSM, the shared cnt and the FIFO.

Test Plan:
1. Pack basic: LANES=1, mode=0, in_data=10'h186 (trits 2,1,0,2,1) accepted at T -> out_valid at T+5, out_data=10'h08C (140), out_err=0.
2. Unpack basic and error:
   - in_data=8'hF2 -> out_data=10'h2AA (all trits 2), err=0.
   - Next transaction in_data=8'hFF -> out_data=10'h014, err=1.
3. Illegal trit: pack with t2=2'b11, others 0 -> out_data=0, out_err=1; trits all 2'b11 -> out_data=0, err=1.
4. Backpressure: FIFO_DEPTH=4, out_ready=0, 5 groups offered -> 4 accepted, in_ready stays 0.
   - Raise out_ready for one cycle -> 1 pop; in_ready=1 next cycle; 5th group accepted.
   - Output order preserved.
5. Multi-lane: LANES=4, pack groups 0x000, 0x2AA, 0x186, 0x155 -> out bytes 0, 242, 140, 121 in their slots after 6 cycles.
6. Reset/flush:
   - rst_n low at T+3 of a RUN -> immediate out_valid=0, busy=0; no output appears after release.
   - flush with 2 FIFO entries -> out_valid=0 next cycle; the following accept behaves as in scenario 1.
